// File: rtl/decap_head_pkg.sv
// Shared widths, tag bit positions, slice payload and FSM states for the decap head path.
package decap_head_pkg;

   localparam int unsigned HEAD_WIDTH       = 512;
   localparam int unsigned TAG_WIDTH        = 8;
   localparam int unsigned SHIFT_WIDTH      = 16;
   localparam int unsigned ENCAP_WIDTH      = 64;
   localparam int unsigned UNITS            = HEAD_WIDTH / SHIFT_WIDTH;
   localparam int unsigned MAX_LEN          = ENCAP_WIDTH / SHIFT_WIDTH;
   localparam int unsigned HEAD_SHIFT_WIDTH = $clog2(UNITS);
   localparam int unsigned META_SHIFT_WIDTH = $clog2(MAX_LEN + 1);
   localparam int unsigned SLICE_W          = HEAD_WIDTH + TAG_WIDTH;
   localparam int unsigned SOFF_W           = 4;
   // off+len in units, one bit wider than an offset so the sum cannot wrap
   localparam int unsigned END_W            = HEAD_SHIFT_WIDTH + 1;
   // bit-level shift amounts, wide enough for a full-slice shift and beyond
   localparam int unsigned AMT_W            = $clog2(HEAD_WIDTH) + 2;
   // slice index counter, saturates well above the largest slice offset
   localparam int unsigned CNT_W            = SOFF_W + 1;

   localparam int unsigned TAG_START_BIT    = 0;
   localparam int unsigned TAG_VALID_BIT    = 1;
   localparam int unsigned TAG_TAIL_BIT     = 2;

   localparam logic [TAG_WIDTH-1:0] TAG_TAIL_MASK = TAG_WIDTH'(1) << TAG_TAIL_BIT;

   typedef struct packed {
      logic [TAG_WIDTH-1:0]  tag;
      logic [HEAD_WIDTH-1:0] data;
   } slice_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_CUT  = 2'd2,
      ST_POST = 2'd3
   } state_e;

endpackage

// File: rtl/decap_shifter.sv
// Removes len units starting at unit off (counted from the MSB) and back-fills from the next slice.
module decap_shifter
   import decap_head_pkg::*;
(
   input  logic [HEAD_WIDTH-1:0]       i_cur,
   input  logic [HEAD_WIDTH-1:0]       i_next,
   input  logic [HEAD_SHIFT_WIDTH-1:0] i_off,
   input  logic [META_SHIFT_WIDTH-1:0] i_len,
   output logic [HEAD_WIDTH-1:0]       o_slice,
   output logic [ENCAP_WIDTH-1:0]      o_field
);

   logic [END_W-1:0]       w_end;
   logic [AMT_W-1:0]       w_off_bits;
   logic [AMT_W-1:0]       w_len_bits;
   logic [AMT_W-1:0]       w_end_bits;
   logic [AMT_W-1:0]       w_fill_bits;
   logic [HEAD_WIDTH-1:0]  w_keep;
   logic [HEAD_WIDTH-1:0]  w_rest;
   logic [HEAD_WIDTH-1:0]  w_fill;
   logic [ENCAP_WIDTH-1:0] w_field_mask;

   // unit counts to bit counts
   assign w_end       = END_W'(i_off) + END_W'(i_len);
   assign w_off_bits  = AMT_W'(i_off) * AMT_W'(SHIFT_WIDTH);
   assign w_len_bits  = AMT_W'(i_len) * AMT_W'(SHIFT_WIDTH);
   assign w_end_bits  = AMT_W'(w_end) * AMT_W'(SHIFT_WIDTH);
   assign w_fill_bits = AMT_W'(HEAD_WIDTH) - w_len_bits;

   // units ahead of the field stay put, units behind it move up by len
   assign w_keep = i_cur & ~({HEAD_WIDTH{1'b1}} >> w_off_bits);
   assign w_rest = (i_cur << w_end_bits) >> w_off_bits;
   assign w_fill = (i_len == '0) ? '0 : (i_next >> w_fill_bits);

   assign o_slice = w_keep | w_rest | w_fill;

   // removed units, MSB-aligned with zero padding below
   assign w_field_mask = ~({ENCAP_WIDTH{1'b1}} >> w_len_bits);
   assign o_field      = ENCAP_WIDTH'((i_cur << w_off_bits) >> (HEAD_WIDTH - ENCAP_WIDTH)) & w_field_mask;

endmodule

// File: rtl/decap_head.sv
// Strips a configurable field of units out of a sliced packet head and reports it on the side.
module decap_head
   import decap_head_pkg::*;
(
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [SLICE_W-1:0]          i_head,
   input  logic [SOFF_W-1:0]           i_decapSliceOffset,
   input  logic [HEAD_SHIFT_WIDTH-1:0] i_decapUnitOffset,
   input  logic [META_SHIFT_WIDTH-1:0] i_decapLength,
   output logic [SLICE_W-1:0]          o_head,
   output logic [ENCAP_WIDTH-1:0]      o_decapField,
   output logic                        o_decapFieldValid,
   output logic                        o_err
);

   // r_state is the role of the slice sitting in r_hold (IDLE = nothing held)
   state_e                      r_state;
   slice_t                      r_hold;
   logic                        r_hold_err;
   logic [CNT_W-1:0]            r_cnt;
   logic [SOFF_W-1:0]           r_soff;
   logic [HEAD_SHIFT_WIDTH-1:0] r_off;
   logic [META_SHIFT_WIDTH-1:0] r_len;
   logic                        r_bad;

   slice_t                      w_in;
   logic                        w_acc, w_start, w_tail;
   logic                        w_busy, w_hold_tail, w_open;
   logic                        w_take, w_cont, w_flush, w_emit;
   logic [SOFF_W-1:0]           w_soff;
   logic [META_SHIFT_WIDTH-1:0] w_len;
   logic [END_W-1:0]            w_end;
   logic                        w_bad_new, w_bad, w_early_err;
   logic [CNT_W-1:0]            w_idx;
   state_e                      w_mode;
   logic [HEAD_WIDTH-1:0]       w_next;
   logic [HEAD_WIDTH-1:0]       w_sh_data;
   logic [ENCAP_WIDTH-1:0]      w_field;
   logic [HEAD_SHIFT_WIDTH-1:0] w_sh_off;
   logic [META_SHIFT_WIDTH-1:0] w_sh_len;
   logic [TAG_WIDTH-1:0]        w_tag_out;

   // slice acceptance and emission decisions
   assign w_in        = i_head;
   assign w_acc       = w_in.tag[TAG_VALID_BIT];
   assign w_start     = w_acc & w_in.tag[TAG_START_BIT];
   assign w_tail      = w_in.tag[TAG_TAIL_BIT];
   assign w_busy      = (r_state != ST_IDLE);
   assign w_hold_tail = w_busy & r_hold.tag[TAG_TAIL_BIT];
   assign w_open      = w_busy & ~r_hold.tag[TAG_TAIL_BIT];
   assign w_take      = w_acc & (w_start | w_open);
   assign w_cont      = w_acc & ~w_start & w_open;
   assign w_flush     = w_start & w_open;
   assign w_emit      = w_hold_tail | w_cont | w_flush;

   // configuration in force for the slice being accepted
   assign w_end       = END_W'(i_decapUnitOffset) + END_W'(i_decapLength);
   assign w_bad_new   = (w_end > END_W'(UNITS)) || (i_decapLength > META_SHIFT_WIDTH'(MAX_LEN));
   assign w_bad       = w_start ? w_bad_new : r_bad;
   assign w_soff      = w_start ? i_decapSliceOffset : r_soff;
   assign w_len       = w_start ? i_decapLength : r_len;
   assign w_idx       = w_start ? '0 : ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
   assign w_early_err = w_tail & ~w_bad & (w_idx < CNT_W'(w_soff));

   // role of the accepted slice relative to the target slice
   always_comb begin
      w_mode = ST_PRE;
      if (!w_bad && (w_len != '0)) begin
         if (w_idx == CNT_W'(w_soff))
            w_mode = ST_CUT;
         else if (w_idx > CNT_W'(w_soff))
            w_mode = ST_POST;
      end
   end

   // shifter operands for the held slice; fill comes only from a continuing slice of the same packet
   assign w_next    = w_cont ? w_in.data : '0;
   assign w_sh_off  = (r_state == ST_CUT) ? r_off : '0;
   assign w_sh_len  = ((r_state == ST_CUT) || (r_state == ST_POST)) ? r_len : '0;
   assign w_tag_out = r_hold.tag | (w_flush ? TAG_TAIL_MASK : '0);

   decap_shifter u_shifter (
      .i_cur   (r_hold.data),
      .i_next  (w_next),
      .i_off   (w_sh_off),
      .i_len   (w_sh_len),
      .o_slice (w_sh_data),
      .o_field (w_field)
   );

   // FSM, holding register, sampled configuration and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state           <= ST_IDLE;
         r_hold            <= '0;
         r_hold_err        <= 1'b0;
         r_cnt             <= '0;
         r_soff            <= '0;
         r_off             <= '0;
         r_len             <= '0;
         r_bad             <= 1'b0;
         o_head            <= '0;
         o_decapField      <= '0;
         o_decapFieldValid <= 1'b0;
         o_err             <= 1'b0;
      end else begin
         o_err <= (w_start & w_bad_new) | w_flush | (w_hold_tail & r_hold_err);
         if (w_emit) begin
            o_head            <= {w_tag_out, w_sh_data};
            o_decapFieldValid <= (r_state == ST_CUT);
            o_decapField      <= (r_state == ST_CUT) ? w_field : '0;
         end else begin
            o_head            <= '0;
            o_decapFieldValid <= 1'b0;
            o_decapField      <= '0;
         end

         if (w_take) begin
            r_hold     <= w_in;
            r_hold_err <= w_early_err;
            r_state    <= w_mode;
            r_cnt      <= w_idx;
            if (w_start) begin
               r_soff <= i_decapSliceOffset;
               r_off  <= i_decapUnitOffset;
               r_len  <= i_decapLength;
               r_bad  <= w_bad_new;
            end
         end else if (w_hold_tail) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_hold_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decap_head.sv
// Randomized scoreboard bench for decap_head against a flat unit-stream reference model.
module tb_decap_head;
   import decap_head_pkg::*;

   logic                        clk   = 1'b0;
   logic                        rst_n = 1'b0;
   logic [SLICE_W-1:0]          i_head = '0;
   logic [SOFF_W-1:0]           i_so   = '0;
   logic [HEAD_SHIFT_WIDTH-1:0] i_uo   = '0;
   logic [META_SHIFT_WIDTH-1:0] i_len  = '0;
   logic [SLICE_W-1:0]          o_head;
   logic [ENCAP_WIDTH-1:0]      o_field;
   logic                        o_fv;
   logic                        o_err;

   always #5 clk = ~clk;

   decap_head dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_head             (i_head),
      .i_decapSliceOffset (i_so),
      .i_decapUnitOffset  (i_uo),
      .i_decapLength      (i_len),
      .o_head             (o_head),
      .o_decapField       (o_field),
      .o_decapFieldValid  (o_fv),
      .o_err              (o_err)
   );

   typedef struct {
      logic [SLICE_W-1:0]     head;
      bit                     fv;
      logic [ENCAP_WIDTH-1:0] field;
   } exp_t;

   exp_t                  exp_q[$];
   int                    n_checks = 0;
   int                    n_errors = 0;
   int                    err_seen = 0;
   int                    err_exp  = 0;
   logic [HEAD_WIDTH-1:0] pkt_d[8];
   logic [TAG_WIDTH-1:0]  pkt_t[8];

   task automatic chk(input string name, input logic [SLICE_W-1:0] act, input logic [SLICE_W-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic logic [HEAD_WIDTH-1:0] rand_data();
      logic [HEAD_WIDTH-1:0] d;
      for (int w = 0; w < HEAD_WIDTH / 32; w++) d[32*w +: 32] = $urandom;
      return d;
   endfunction

   task automatic fill_pkt(input int n, input bit tail);
      for (int i = 0; i < n; i++) begin
         logic [TAG_WIDTH-1:0] t;
         t = TAG_WIDTH'($urandom);
         t[TAG_START_BIT] = (i == 0);
         t[TAG_VALID_BIT] = 1'b1;
         t[TAG_TAIL_BIT]  = tail && (i == n - 1);
         pkt_t[i] = t;
         pkt_d[i] = rand_data();
      end
   endtask

   // Reference: flatten the packet into units, cut the field out, pad zeros at the end, re-slice.
   task automatic model(input int n, input bit tail, input int soff, input int off, input int len, input bit first_only);
      logic [15:0]            u[$];
      logic [ENCAP_WIDTH-1:0] fld;
      bit                     bad, cut;
      int                     base, n_out;
      exp_t                   e;
      fld = '0;
      for (int i = 0; i < n; i++) begin
         logic [HEAD_WIDTH-1:0] t;
         t = pkt_d[i];
         for (int k = 0; k < UNITS; k++) u.push_back(t[HEAD_WIDTH-1-16*k -: 16]);
      end
      bad = (off + len > 32) || (len > 4);
      cut = !bad && (len > 0) && (soff < n);
      if (cut) begin
         base = soff * 32 + off;
         for (int j = 0; j < len; j++) fld[ENCAP_WIDTH-1-16*j -: 16] = u[base + j];
         for (int j = 0; j < len; j++) u.delete(base);
         for (int j = 0; j < len; j++) u.push_back(16'h0);
      end
      n_out = first_only ? 1 : n;
      for (int i = 0; i < n_out; i++) begin
         logic [HEAD_WIDTH-1:0] d;
         logic [TAG_WIDTH-1:0]  t;
         for (int k = 0; k < UNITS; k++) d[HEAD_WIDTH-1-16*k -: 16] = u[32*i + k];
         t = pkt_t[i];
         if (i == n - 1 && !tail) t[TAG_TAIL_BIT] = 1'b1;
         e.head  = {t, d};
         e.fv    = cut && (i == soff);
         e.field = fld;
         exp_q.push_back(e);
      end
      if (!first_only) begin
         if (bad) err_exp++;
         if (!bad && tail && n <= soff) err_exp++;
         if (!tail) err_exp++;
      end
   endtask

   task automatic drive(input logic [SLICE_W-1:0] h, input logic [SOFF_W-1:0] so,
                        input logic [HEAD_SHIFT_WIDTH-1:0] uo, input logic [META_SHIFT_WIDTH-1:0] ln);
      @(negedge clk);
      i_head = h;
      i_so   = so;
      i_uo   = uo;
      i_len  = ln;
   endtask

   task automatic idle(input int k);
      for (int c = 0; c < k; c++) begin
         logic [SLICE_W-1:0] h;
         h = {TAG_WIDTH'($urandom), rand_data()};
         h[HEAD_WIDTH + TAG_VALID_BIT] = 1'b0;
         drive(h, SOFF_W'($urandom), HEAD_SHIFT_WIDTH'($urandom), META_SHIFT_WIDTH'($urandom));
      end
   endtask

   task automatic send(input int n, input bit tail, input int soff, input int off, input int len, input bit gaps);
      model(n, tail, soff, off, len, 1'b0);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
         if (i == 0)
            drive({pkt_t[0], pkt_d[0]}, SOFF_W'(soff), HEAD_SHIFT_WIDTH'(off), META_SHIFT_WIDTH'(len));
         else
            drive({pkt_t[i], pkt_d[i]}, SOFF_W'($urandom), HEAD_SHIFT_WIDTH'($urandom), META_SHIFT_WIDTH'($urandom));
      end
      if (tail) begin
         idle(2);
         #1 chk("err_count", SLICE_W'(err_seen), SLICE_W'(err_exp));
      end
   endtask

   // Monitor: pops the scoreboard whenever a valid slice appears, counts error strobes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_err) err_seen++;
         if (o_head[HEAD_WIDTH + TAG_VALID_BIT]) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_slice: got %h, required no output", o_head);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("head", o_head, e.head);
               chk("field_valid", SLICE_W'(o_fv), SLICE_W'(e.fv));
               if (e.fv) chk("field", SLICE_W'(o_field), SLICE_W'(e.field));
            end
         end else begin
            chk("idle_strobe", SLICE_W'(o_fv), '0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit force_good;
      force_good = 1'b0;

      // reset state
      idle(2);
      #1;
      chk("rst_head",  o_head, '0);
      chk("rst_field", SLICE_W'(o_field), '0);
      chk("rst_fv",    SLICE_W'(o_fv), '0);
      chk("rst_err",   SLICE_W'(o_err), '0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // directed cases
      fill_pkt(3, 1'b1); send(3, 1'b1, 0, 0, 4, 1'b0);   // field at the very front
      fill_pkt(3, 1'b1); send(3, 1'b1, 1, 30, 2, 1'b0);  // field at the end of slice 1
      fill_pkt(2, 1'b1); send(2, 1'b1, 0, 7, 0, 1'b0);   // zero length
      fill_pkt(2, 1'b1); send(2, 1'b1, 0, 30, 4, 1'b0);  // field overruns the slice
      fill_pkt(1, 1'b1); send(1, 1'b1, 2, 0, 2, 1'b0);   // tail before the target slice
      fill_pkt(2, 1'b0); send(2, 1'b0, 0, 5, 3, 1'b0);   // packet cut short by a new start
      fill_pkt(3, 1'b1); send(3, 1'b1, 1, 10, 4, 1'b0);

      // reset in the middle of a packet
      fill_pkt(3, 1'b1);
      model(3, 1'b1, 0, 3, 2, 1'b1);
      drive({pkt_t[0], pkt_d[0]}, 4'd0, 5'd3, 3'd2);
      drive({pkt_t[1], pkt_d[1]}, 4'd0, 5'd0, 3'd0);
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_head",  o_head, '0);
      chk("midrst_field", SLICE_W'(o_field), '0);
      chk("midrst_fv",    SLICE_W'(o_fv), '0);
      chk("midrst_err",   SLICE_W'(o_err), '0);
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      drive({pkt_t[1], pkt_d[1]}, 4'd0, 5'd0, 3'd1);  // valid, no start: must be ignored
      idle(3);
      #1 chk("post_reset_queue", SLICE_W'(exp_q.size()), '0);

      // random packets
      for (int p = 0; p < 40; p++) begin
         int n, so, of, ln;
         bit tl;
         n  = $urandom_range(1, 4);
         so = $urandom_range(0, 4);
         ln = $urandom_range(0, 4);
         of = $urandom_range(0, 32 - ln);
         if (!force_good && $urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               of = $urandom_range(29, 31);
               ln = 4;
            end else begin
               ln = $urandom_range(5, 7);
               of = $urandom_range(0, 31);
            end
         end
         tl = !((p != 39) && ($urandom_range(0, 5) == 0));
         force_good = !tl;
         fill_pkt(n, tl);
         send(n, tl, so, of, ln, 1'b1);
         if (tl && $urandom_range(0, 3) == 0) begin
            logic [SLICE_W-1:0] j;
            j = {TAG_WIDTH'($urandom), rand_data()};
            j[HEAD_WIDTH + TAG_VALID_BIT] = 1'b1;
            j[HEAD_WIDTH + TAG_START_BIT] = 1'b0;
            drive(j, SOFF_W'($urandom), HEAD_SHIFT_WIDTH'($urandom), META_SHIFT_WIDTH'($urandom));
            idle(1);
         end
      end

      idle(5);
      #1;
      chk("final_queue", SLICE_W'(exp_q.size()), '0);
      chk("final_err_count", SLICE_W'(err_seen), SLICE_W'(err_exp));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
